seq_divider_8b: RTL

//  Iterative radix-2 restoring divider: 8-bit unsigned dividend / 4-bit unsigned divisor -> quotient + remainder.

---
 rtl/seq_divider_8b_pkg.sv | 19 +
 rtl/seq_divider_8b_div_sub.sv | 52 +++++
 rtl/seq_divider_8b.sv | 110 +++++++++++
 3 files changed

// File: rtl/seq_divider_8b_pkg.sv
// Shared types and defaults for the sequential restoring divider.
// Widths default to the product/operand widths of the 4x4 multiplier it checks.
package seq_divider_8b_pkg;

    localparam int unsigned WxDefault = 8;
    localparam int unsigned WyDefault = 4;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    // Iteration counter must be able to hold the value wx.
    function automatic int unsigned cnt_width(input int unsigned wx);
        return $clog2(wx + 1);
    endfunction

endpackage

// File: rtl/seq_divider_8b_div_sub.sv
// W-bit subtractor a + ~b + 1 using a parallel-prefix carry network.
// carry = 1 means a >= b (no borrow).
module div_sub #(
    parameter int unsigned W = 5
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff,
    output logic         carry
);

    localparam int unsigned Levels = $clog2(W);

    logic [W-1:0] prop0;
    logic [W-1:0] gen_pfx;

    assign prop0 = a ^ ~b;

    always_comb begin
        logic [W-1:0] g;
        logic [W-1:0] p;
        logic [W-1:0] g_nx;
        logic [W-1:0] p_nx;
        g_nx = '0;
        p_nx = '0;
        g    = a & ~b;
        p    = prop0;
        // Carry-in of 1 folded into bit 0 so every prefix G is directly a carry.
        g[0] = g[0] | p[0];
        for (int lvl = 0; lvl < int'(Levels); lvl++) begin
            g_nx = g;
            p_nx = p;
            for (int i = 0; i < int'(W); i++) begin
                if (i >= (1 << lvl)) begin
                    // Grey cell: neighbour span already reaches bit 0, only G needed.
                    g_nx[i] = g[i] | (p[i] & g[i - (1 << lvl)]);
                    // Black cell: span still open, keep P for later levels.
                    if (i >= (2 << lvl)) begin
                        p_nx[i] = p[i] & p[i - (1 << lvl)];
                    end
                end
            end
            g = g_nx;
            p = p_nx;
        end
        gen_pfx = g;
    end

    assign diff  = prop0 ^ {gen_pfx[W-2:0], 1'b1};
    assign carry = gen_pfx[W-1];

endmodule

// File: rtl/seq_divider_8b.sv
// Iterative radix-2 restoring divider, WX-bit dividend by WY-bit divisor,
// one quotient bit per cycle, valid/ready on both sides.
module seq_divider_8b
    import seq_divider_8b_pkg::*;
#(
    parameter int unsigned WX = WxDefault,
    parameter int unsigned WY = WyDefault
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [WX-1:0] x,
    input  logic [WY-1:0] y,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [WX-1:0] q,
    output logic [WY-1:0] r,
    output logic          div0
);

    localparam int unsigned CntW = cnt_width(WX);

    state_e        state_q;
    logic [WX-1:0] dvd_q;
    logic [WY-1:0] dsr_q;
    logic [WY:0]   rem_q;
    logic [CntW-1:0] cnt_q;

    logic [WY:0]   rem_shift;
    logic [WY:0]   diff;
    logic [WY:0]   rem_next;
    logic          no_borrow;
    logic          take_diff;
    logic [WX-1:0] quo_next;

    assign rem_shift = {rem_q[WY-1:0], dvd_q[WX-1]};

    div_sub #(
        .W(WY + 1)
    ) u_div_sub (
        .a    (rem_shift),
        .b    ({1'b0, dsr_q}),
        .diff (diff),
        .carry(no_borrow)
    );

    // A set bit shifted out of rem would always exceed the divisor.
    assign take_diff = no_borrow | rem_q[WY];
    assign rem_next  = take_diff ? diff : rem_shift;
    // Quotient bits enter at the LSB as dividend bits leave at the MSB.
    assign quo_next  = {dvd_q[WX-2:0], take_diff};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            dvd_q     <= '0;
            dsr_q     <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            q         <= '0;
            r         <= '0;
            div0      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid && in_ready) begin
                        dvd_q    <= x;
                        dsr_q    <= y;
                        rem_q    <= '0;
                        cnt_q    <= '0;
                        in_ready <= 1'b0;
                        state_q  <= (y != '0) ? StRun : StDone;
                    end
                end
                StRun: begin
                    dvd_q <= quo_next;
                    rem_q <= rem_next;
                    cnt_q <= cnt_q + CntW'(1);
                    if (cnt_q == CntW'(WX - 1)) begin
                        q         <= quo_next;
                        r         <= rem_next[WY-1:0];
                        div0      <= 1'b0;
                        out_valid <= 1'b1;
                        state_q   <= StDone;
                    end
                end
                StDone: begin
                    // Entered with out_valid low only on the divide-by-zero path.
                    if (!out_valid) begin
                        q         <= '1;
                        r         <= dvd_q[WY-1:0];
                        div0      <= 1'b1;
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_q   <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
